int_dispatch: RTL and testbench

- Downstream consumer of the interrupt controller's NEXT_ID/NEXT_ON/RESET_ON outputs.
- On a pending interrupt, waits for an instruction boundary, then stalls the core and pushes PC high, PC low and FLAGS to the stack.
- Then fetches the 16-bit handler vector from the vector table, loads it into the PC and pulses ACK back to the controller.
- The reset interrupt (ID 8) skips the stack pushes and is never masked.

---
 rtl/int_dispatch_pkg.sv | 49 ++++
 rtl/int_vec_fetch.sv | 70 +++++++
 rtl/int_dispatch.sv | 172 +++++++++++++++++
 tb/tb_int_dispatch.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_dispatch_pkg.sv
// Shared definitions for the interrupt dispatch path: state encodings,
// interrupt ID constants common with the controller, and vector table helpers.
package int_dispatch_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_BND,
        S_PUSH_H,
        S_PUSH_L,
        S_PUSH_F,
        S_FETCH_L,
        S_FETCH_H,
        S_LOAD,
        S_ACKW
    } disp_state_e;

    typedef enum logic [1:0] {
        F_IDLE,
        F_LO,
        F_HI
    } fetch_state_e;

    localparam logic [3:0] ID_EXT0 = 4'd0;
    localparam logic [3:0] ID_EXT1 = 4'd1;
    localparam logic [3:0] ID_EXT2 = 4'd2;
    localparam logic [3:0] ID_EXT3 = 4'd3;
    localparam logic [3:0] ID_DMAD = 4'd4;
    localparam logic [3:0] ID_DMAF = 4'd5;
    localparam logic [3:0] ID_STOF = 4'd6;
    localparam logic [3:0] ID_STUF = 4'd7;
    localparam logic [3:0] ID_RSTB = 4'd8;
    localparam logic [3:0] ID_SFT0 = 4'd9;
    localparam logic [3:0] ID_SFT1 = 4'd10;
    localparam logic [3:0] ID_SFT2 = 4'd11;
    localparam logic [3:0] ID_SFT3 = 4'd12;
    localparam logic [3:0] ID_SFT4 = 4'd13;
    localparam logic [3:0] ID_SFT5 = 4'd14;
    localparam logic [3:0] ID_IRQ0 = 4'd15;

    localparam logic [15:0] VEC_BASE_DEF = 16'hFFE0;

    // Two bytes per vector entry; the sum deliberately wraps at 16 bits.
    function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                             input logic [3:0]  id,
                                             input logic        hi);
        return base + {11'b0, id, 1'b0} + {15'b0, hi};
    endfunction

endpackage

// File: rtl/int_vec_fetch.sv
// Two-byte handler vector read: low byte then high byte from the vector table.
// Started by a one-cycle pulse; abort drops any read in flight.
module int_vec_fetch
    import int_dispatch_pkg::*;
#(
    parameter logic [15:0] VEC_BASE = VEC_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  id,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data,
    input  logic        mem_valid,
    output logic [15:0] vector,
    output logic        lo_done,
    output logic        done
);

    fetch_state_e fstate, fstate_nxt;
    logic [15:0]  vec_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fstate <= F_IDLE;
            vec_r  <= 16'h0000;
        end else begin
            fstate <= fstate_nxt;
            if (lo_done) vec_r[7:0]  <= mem_data;
            if (done)    vec_r[15:8] <= mem_data;
        end
    end

    always_comb begin
        fstate_nxt = fstate;
        mem_req    = 1'b0;
        mem_addr   = 16'h0000;
        lo_done    = 1'b0;
        done       = 1'b0;
        if (abort) begin
            fstate_nxt = F_IDLE;
        end else begin
            case (fstate)
                F_IDLE: if (start) fstate_nxt = F_LO;
                F_LO: begin
                    mem_req  = 1'b1;
                    mem_addr = vec_addr(VEC_BASE, id, 1'b0);
                    if (mem_valid) begin
                        lo_done    = 1'b1;
                        fstate_nxt = F_HI;
                    end
                end
                F_HI: begin
                    mem_req  = 1'b1;
                    mem_addr = vec_addr(VEC_BASE, id, 1'b1);
                    if (mem_valid) begin
                        done       = 1'b1;
                        fstate_nxt = F_IDLE;
                    end
                end
                default: fstate_nxt = F_IDLE;
            endcase
        end
    end

    assign vector = vec_r;

endmodule

// File: rtl/int_dispatch.sv
// Interrupt dispatcher: waits for an instruction boundary, stacks PC/FLAGS,
// fetches the handler vector and loads it into the core's PC.
module int_dispatch
    import int_dispatch_pkg::*;
#(
    parameter logic [15:0] VEC_BASE = VEC_BASE_DEF,
    parameter logic [3:0]  RST_ID   = ID_RSTB
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  NEXT_ID,
    input  logic        NEXT_ON,
    input  logic        RESET_ON,
    output logic        ACK,
    input  logic [15:0] MASK,
    input  logic        GIE,
    input  logic        INSTR_DONE,
    input  logic [15:0] PC_IN,
    input  logic [7:0]  FLAGS_IN,
    output logic        STALL,
    output logic        GIE_CLR,
    output logic        PUSH_REQ,
    output logic [7:0]  PUSH_DATA,
    input  logic        PUSH_ACK,
    output logic        MEM_REQ,
    output logic [15:0] MEM_ADDR,
    input  logic [7:0]  MEM_DATA,
    input  logic        MEM_VALID,
    output logic        PC_LOAD,
    output logic [15:0] PC_OUT,
    output logic        DROPPED
);

    disp_state_e state, state_nxt;
    logic [3:0]  id_r;
    logic [15:0] pc_r;
    logic [7:0]  flags_r;
    logic        drop_ack;
    logic        drop_r;

    logic latch_id, latch_ctx, drop_set, fetch_start;
    logic fetch_lo_done, fetch_done;
    logic [15:0] vector;

    int_vec_fetch #(.VEC_BASE(VEC_BASE)) u_fetch (
        .clk       (CLK),
        .rst_n     (RST),
        .start     (fetch_start),
        .abort     (RESET_ON),
        .id        (id_r),
        .mem_req   (MEM_REQ),
        .mem_addr  (MEM_ADDR),
        .mem_data  (MEM_DATA),
        .mem_valid (MEM_VALID),
        .vector    (vector),
        .lo_done   (fetch_lo_done),
        .done      (fetch_done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            id_r     <= 4'h0;
            pc_r     <= 16'h0000;
            flags_r  <= 8'h00;
            drop_ack <= 1'b0;
            drop_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            drop_ack <= drop_set;
            if (latch_id) begin
                id_r   <= NEXT_ID;
                drop_r <= drop_set;
            end
            if (latch_ctx) begin
                pc_r    <= PC_IN;
                flags_r <= FLAGS_IN;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        latch_id    = 1'b0;
        latch_ctx   = 1'b0;
        drop_set    = 1'b0;
        fetch_start = 1'b0;
        STALL       = 1'b0;
        GIE_CLR     = 1'b0;
        PUSH_REQ    = 1'b0;
        PUSH_DATA   = 8'h00;
        PC_LOAD     = 1'b0;
        ACK         = 1'b0;
        DROPPED     = 1'b0;
        if (RESET_ON) begin
            STALL     = 1'b1;
            state_nxt = S_IDLE;
        end else begin
            // A dropped interrupt acknowledges one cycle after it was seen.
            ACK     = drop_ack;
            DROPPED = drop_ack;
            case (state)
                S_IDLE: begin
                    if (NEXT_ON) begin
                        latch_id = 1'b1;
                        if (NEXT_ID == RST_ID) begin
                            state_nxt   = S_FETCH_L;
                            fetch_start = 1'b1;
                        end else if (GIE && MASK[NEXT_ID]) begin
                            state_nxt = S_WAIT_BND;
                        end else begin
                            state_nxt = S_ACKW;
                            drop_set  = 1'b1;
                        end
                    end
                end
                S_WAIT_BND: begin
                    if (INSTR_DONE) begin
                        latch_ctx = 1'b1;
                        GIE_CLR   = 1'b1;
                        state_nxt = S_PUSH_H;
                    end
                end
                S_PUSH_H: begin
                    STALL     = 1'b1;
                    PUSH_REQ  = 1'b1;
                    PUSH_DATA = pc_r[15:8];
                    if (PUSH_ACK) state_nxt = S_PUSH_L;
                end
                S_PUSH_L: begin
                    STALL     = 1'b1;
                    PUSH_REQ  = 1'b1;
                    PUSH_DATA = pc_r[7:0];
                    if (PUSH_ACK) state_nxt = S_PUSH_F;
                end
                S_PUSH_F: begin
                    STALL     = 1'b1;
                    PUSH_REQ  = 1'b1;
                    PUSH_DATA = flags_r;
                    if (PUSH_ACK) begin
                        state_nxt   = S_FETCH_L;
                        fetch_start = 1'b1;
                    end
                end
                S_FETCH_L: begin
                    STALL = 1'b1;
                    if (fetch_lo_done) state_nxt = S_FETCH_H;
                end
                S_FETCH_H: begin
                    STALL = 1'b1;
                    if (fetch_done) state_nxt = S_LOAD;
                end
                S_LOAD: begin
                    STALL     = 1'b1;
                    PC_LOAD   = 1'b1;
                    ACK       = 1'b1;
                    state_nxt = S_ACKW;
                end
                S_ACKW: begin
                    // Holding here until the controller retracts NEXT_ON keeps
                    // the same ID from being dispatched twice.
                    STALL = ~drop_r;
                    if (!NEXT_ON) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign PC_OUT = vector;

endmodule

// File: tb/tb_int_dispatch.sv
// Scoreboard bench for int_dispatch: directed scenarios push expected events,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_int_dispatch;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  NEXT_ID = 4'h0;
    logic        NEXT_ON = 1'b0;
    logic        RESET_ON = 1'b0;
    logic        ACK;
    logic [15:0] MASK = 16'h0000;
    logic        GIE = 1'b0;
    logic        INSTR_DONE = 1'b0;
    logic [15:0] PC_IN = 16'h0000;
    logic [7:0]  FLAGS_IN = 8'h00;
    logic        STALL, GIE_CLR, PUSH_REQ;
    logic [7:0]  PUSH_DATA;
    logic        PUSH_ACK = 1'b0;
    logic        MEM_REQ;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_DATA = 8'h00;
    logic        MEM_VALID = 1'b0;
    logic        PC_LOAD;
    logic [15:0] PC_OUT;
    logic        DROPPED;

    int_dispatch dut (
        .CLK(CLK), .RST(RST), .NEXT_ID(NEXT_ID), .NEXT_ON(NEXT_ON),
        .RESET_ON(RESET_ON), .ACK(ACK), .MASK(MASK), .GIE(GIE),
        .INSTR_DONE(INSTR_DONE), .PC_IN(PC_IN), .FLAGS_IN(FLAGS_IN),
        .STALL(STALL), .GIE_CLR(GIE_CLR), .PUSH_REQ(PUSH_REQ),
        .PUSH_DATA(PUSH_DATA), .PUSH_ACK(PUSH_ACK), .MEM_REQ(MEM_REQ),
        .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_VALID(MEM_VALID),
        .PC_LOAD(PC_LOAD), .PC_OUT(PC_OUT), .DROPPED(DROPPED)
    );

    always #5 CLK = ~CLK;

    localparam int K_GCLR = 1, K_PUSH = 2, K_MEM = 3, K_LOAD = 4,
                   K_LOADX = 5, K_ACK = 6, K_DROPX = 7;

    typedef struct {
        int          kind;
        logic [15:0] data;
    } ev_t;

    ev_t sb[$];
    int  total = 0, bad = 0;
    int  cyc = 0;
    int  push_wait = 0, mem_wait = 0, pcnt = 0, mcnt = 0;
    int  gclr_cyc = 0, load_cyc = 0, ack_cyc = 0;
    int  stall_cnt = 0, stall_runs = 0, push_cnt = 0, ack_cnt = 0;
    bit  ack_seen = 0;
    bit  prev_stall = 0, prev_preq = 0, prev_pack = 0, prev_mreq = 0, prev_mval = 0;
    logic [7:0]  prev_pdata = 8'h00;
    logic [15:0] prev_maddr = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic sb_push(input int kind, input logic [15:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic sb_check(input int kind, input logic [15:0] data);
        ev_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected event: got kind=%0d data=%h want none", kind, data);
        end else begin
            e = sb.pop_front();
            chk("event kind", 32'(kind), 32'(e.kind));
            chk("event data", 32'(data), 32'(e.data));
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'hFFE8: return 8'h00;
            16'hFFE9: return 8'h80;
            16'hFFF0: return 8'h34;
            16'hFFF1: return 8'hC0;
            16'hFFFE: return 8'hCD;
            16'hFFFF: return 8'hAB;
            default:  return 8'hEE;
        endcase
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Stack and memory responders with programmable wait cycles.
    always @(posedge CLK) begin
        #1;
        if (PUSH_REQ) begin
            if (pcnt >= push_wait) begin PUSH_ACK = 1'b1; pcnt = 0; end
            else begin PUSH_ACK = 1'b0; pcnt++; end
        end else begin
            PUSH_ACK = 1'b0; pcnt = 0;
        end
        if (MEM_REQ) begin
            if (mcnt >= mem_wait) begin MEM_VALID = 1'b1; MEM_DATA = mem_byte(MEM_ADDR); mcnt = 0; end
            else begin MEM_VALID = 1'b0; MEM_DATA = 8'h00; mcnt++; end
        end else begin
            MEM_VALID = 1'b0; MEM_DATA = 8'h00; mcnt = 0;
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            prev_stall = 0; prev_preq = 0; prev_pack = 0; prev_mreq = 0; prev_mval = 0;
        end else begin
            if (GIE_CLR) begin sb_check(K_GCLR, 16'h0000); gclr_cyc = cyc; end
            if (PUSH_REQ && PUSH_ACK) begin sb_check(K_PUSH, {8'h00, PUSH_DATA}); push_cnt++; end
            if (MEM_REQ && MEM_VALID) sb_check(K_MEM, MEM_ADDR);
            if (PC_LOAD) begin
                sb_check(ACK ? K_LOAD : K_LOADX, PC_OUT);
                load_cyc = cyc;
            end else if (ACK) begin
                sb_check(K_ACK, {15'b0, DROPPED});
            end else if (DROPPED) begin
                sb_check(K_DROPX, 16'h0000);
            end
            if (ACK) begin ack_seen = 1; ack_cyc = cyc; ack_cnt++; end
            if (PUSH_REQ && prev_preq && !prev_pack) chk("push data hold", 32'(PUSH_DATA), 32'(prev_pdata));
            if (MEM_REQ && prev_mreq && !prev_mval) chk("mem addr hold", 32'(MEM_ADDR), 32'(prev_maddr));
            if (STALL) stall_cnt++;
            if (STALL && !prev_stall) stall_runs++;
            prev_stall = STALL; prev_preq = PUSH_REQ; prev_pack = PUSH_ACK;
            prev_mreq = MEM_REQ; prev_mval = MEM_VALID;
            prev_pdata = PUSH_DATA; prev_maddr = MEM_ADDR;
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_ack(input int lim, input string name);
        for (int i = 0; i < lim; i++) begin
            if (ack_seen) break;
            step();
        end
        if (!ack_seen) begin
            total++;
            bad++;
            $display("FAIL %s: got no ACK want ACK within %0d cycles", name, lim);
        end
    endtask

    task automatic drained(input string name);
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic dispatch(input logic [3:0] id, input logic [15:0] mask,
                            input logic [15:0] pc, input logic [7:0] fl,
                            input logic [15:0] addr_lo, input logic [15:0] vec,
                            input int hold);
        sb_push(K_GCLR, 16'h0000);
        sb_push(K_PUSH, {8'h00, pc[15:8]});
        sb_push(K_PUSH, {8'h00, pc[7:0]});
        sb_push(K_PUSH, {8'h00, fl});
        sb_push(K_MEM, addr_lo);
        sb_push(K_MEM, addr_lo + 16'h0001);
        sb_push(K_LOAD, vec);
        NEXT_ID = id; MASK = mask; GIE = 1'b1; PC_IN = pc; FLAGS_IN = fl;
        stall_cnt = 0; stall_runs = 0; ack_seen = 0;
        NEXT_ON = 1'b1;
        step();
        INSTR_DONE = 1'b1;
        step();
        INSTR_DONE = 1'b0;
        wait_ack(60, "dispatch ack");
        for (int i = 0; i < hold; i++) begin
            chk("ackw stall held", 32'(STALL), 32'd1);
            INSTR_DONE = 1'b1;
            step();
        end
        INSTR_DONE = 1'b0;
        NEXT_ON = 1'b0;
        step();
        chk("stall released", 32'(STALL), 32'd0);
    endtask

    task automatic drop(input logic [3:0] id, input logic [15:0] mask, input logic gie);
        int nx;
        sb_push(K_ACK, 16'h0001);
        NEXT_ID = id; MASK = mask; GIE = gie;
        stall_cnt = 0; ack_seen = 0;
        NEXT_ON = 1'b1;
        nx = cyc;
        wait_ack(10, "drop ack");
        chk("drop ack latency", 32'(ack_cyc - nx), 32'd1);
        NEXT_ON = 1'b0;
        step();
        step();
        chk("drop no stall", 32'(stall_cnt), 32'd0);
        drained("drop drained");
    endtask

    initial begin
        int nx;
        #1;
        chk("reset STALL", 32'(STALL), 32'd0);
        chk("reset ACK", 32'(ACK), 32'd0);
        chk("reset PC_OUT", 32'(PC_OUT), 32'd0);
        step();
        RST = 1'b1;
        step();
        chk("idle outputs", 32'({STALL, GIE_CLR, PUSH_REQ, MEM_REQ, PC_LOAD, ACK, DROPPED}), 32'd0);

        // Nominal, zero-wait
        dispatch(4'd4, 16'h0010, 16'h1234, 8'hA5, 16'hFFE8, 16'h8000, 0);
        chk("nominal latency", 32'(load_cyc - gclr_cyc), 32'd6);
        chk("nominal stall cycles", 32'(stall_cnt), 32'd7);
        chk("nominal stall runs", 32'(stall_runs), 32'd1);
        chk("nominal PC_OUT", 32'(PC_OUT), 32'h8000);
        drained("nominal drained");

        // Masked and GIE-off drops
        drop(4'd2, 16'hFFFB, 1'b1);
        drop(4'd5, 16'hFFFF, 1'b0);

        // Reset vector: no pushes, non-maskable
        RESET_ON = 1'b1; NEXT_ID = 4'd8; NEXT_ON = 1'b1; MASK = 16'h0000; GIE = 1'b0;
        step();
        chk("reset_on STALL", 32'(STALL), 32'd1);
        chk("reset_on no req", 32'({PUSH_REQ, MEM_REQ, ACK}), 32'd0);
        step();
        sb_push(K_MEM, 16'hFFF0);
        sb_push(K_MEM, 16'hFFF1);
        sb_push(K_LOAD, 16'hC034);
        ack_seen = 0;
        RESET_ON = 1'b0;
        nx = cyc;
        wait_ack(20, "reset vector ack");
        chk("reset vector latency", 32'(load_cyc - nx), 32'd3);
        NEXT_ON = 1'b0;
        step();
        drained("reset vector drained");

        // Highest ID, top of vector table
        dispatch(4'd15, 16'h8000, 16'hBEEF, 8'h3C, 16'hFFFE, 16'hABCD, 0);
        drained("id15 drained");

        // Backpressure on stack and memory
        push_wait = 3; mem_wait = 2;
        dispatch(4'd4, 16'h0010, 16'h1234, 8'hA5, 16'hFFE8, 16'h8000, 0);
        chk("bp stall cycles", 32'(stall_cnt), 32'd20);
        chk("bp stall runs", 32'(stall_runs), 32'd1);
        chk("bp PC_OUT", 32'(PC_OUT), 32'h8000);
        drained("bp drained");

        // Reset asserted while pushing PC low
        sb_push(K_GCLR, 16'h0000);
        sb_push(K_PUSH, 16'h0012);
        NEXT_ID = 4'd4; MASK = 16'h0010; GIE = 1'b1; PC_IN = 16'h1234; FLAGS_IN = 8'hA5;
        push_cnt = 0;
        NEXT_ON = 1'b1;
        step();
        INSTR_DONE = 1'b1;
        step();
        INSTR_DONE = 1'b0;
        for (int i = 0; i < 20 && push_cnt < 1; i++) step();
        chk("first push before reset", 32'(push_cnt), 32'd1);
        chk("in PUSH_L data", 32'(PUSH_DATA), 32'h34);
        RST = 1'b0;
        NEXT_ON = 1'b0;
        #1;
        chk("midrst outputs", 32'({STALL, GIE_CLR, PUSH_REQ, MEM_REQ, PC_LOAD, ACK, DROPPED}), 32'd0);
        chk("midrst PUSH_DATA", 32'(PUSH_DATA), 32'd0);
        chk("midrst PC_OUT", 32'(PC_OUT), 32'd0);
        drained("midrst drained");
        step();
        step();
        RST = 1'b1;
        ack_cnt = 0;
        repeat (4) step();
        chk("midrst no stray ack", 32'(ack_cnt), 32'd0);
        chk("midrst idle stall", 32'(STALL), 32'd0);

        // NEXT_ON held after ACK: no re-dispatch
        push_wait = 0; mem_wait = 0;
        dispatch(4'd4, 16'h0010, 16'h5678, 8'h0F, 16'hFFE8, 16'h8000, 4);
        chk("handshake stall cycles", 32'(stall_cnt), 32'd11);
        repeat (3) step();
        drained("handshake drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
